// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction fetch controller: PC, ROM request FSM, 2-entry fetch buffer
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int         BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic        valid_if,
    output logic [31:0] pc_if,
    output logic [31:0] inst
);

    localparam logic [1:0] FULL = BUF_DEPTH[1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] ent_pc_q   [BUF_DEPTH];
    logic [31:0] ent_inst_q [BUF_DEPTH];
    logic [31:0] ent_pc_d   [BUF_DEPTH];
    logic [31:0] ent_inst_d [BUF_DEPTH];

    logic        pop;
    logic        push;
    logic [1:0]  cnt_pop;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^branch_addr[1:0];

    assign pop     = (count_q != 2'd0) && !stall && !branch;
    assign push    = (state_q == REQ) && rom_ack && !branch;
    assign cnt_pop = count_q - {1'b0, pop};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        ent_pc_d[0]   = ent_pc_q[0];
        ent_pc_d[1]   = ent_pc_q[1];
        ent_inst_d[0] = ent_inst_q[0];
        ent_inst_d[1] = ent_inst_q[1];

        // Head lives in entry 0; a pop shifts entry 1 down before any push lands.
        if (branch) begin
            count_d = 2'd0;
            pc_d    = {branch_addr[31:2], 2'b00};
        end else begin
            if (pop) begin
                ent_pc_d[0]   = ent_pc_q[1];
                ent_inst_d[0] = ent_inst_q[1];
            end
            count_d = cnt_pop;
            if (push) begin
                if (cnt_pop == 2'd0) begin
                    ent_pc_d[0]   = pc_q;
                    ent_inst_d[0] = rom_data;
                end else begin
                    ent_pc_d[1]   = pc_q;
                    ent_inst_d[1] = rom_data;
                end
                pc_d    = pc_q + 32'd4;
                count_d = cnt_pop + 2'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (go && (branch || cnt_pop < FULL)) state_d = REQ;
            end
            REQ: begin
                if (branch) begin
                    if (rom_ack) state_d = go ? REQ : IDLE;
                    else         state_d = DROP;
                end else if (rom_ack) begin
                    state_d = (go && (cnt_pop + 2'd1) < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                // The stale response is swallowed; a new redirect keeps us waiting here.
                if (!branch && rom_ack) state_d = go ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            count_q       <= 2'd0;
            ent_pc_q[0]   <= 32'd0;
            ent_pc_q[1]   <= 32'd0;
            ent_inst_q[0] <= 32'd0;
            ent_inst_q[1] <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            ent_pc_q[0]   <= ent_pc_d[0];
            ent_pc_q[1]   <= ent_pc_d[1];
            ent_inst_q[0] <= ent_inst_d[0];
            ent_inst_q[1] <= ent_inst_d[1];
            if (state_q == REQ) req_addr_q <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) assert (count_q <= FULL);
    end

    assign rom_req  = (state_q != IDLE);
    assign rom_addr = (state_q == DROP) ? req_addr_q : pc_q;
    assign valid_if = (count_q != 2'd0);
    assign pc_if    = valid_if ? ent_pc_q[0]   : 32'd0;
    assign inst     = valid_if ? ent_inst_q[0] : 32'd0;

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2 (fixed, not overridable), giving the fetch buffer entry count.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; ports are clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 go  input  1  fetch enable; 0 blocks new ROM requests.
REQ-007 stall  input  1  downstream hold; 1 blocks buffer pop.
REQ-008 branch  input  1  redirect strobe, single-cycle.
REQ-009 branch_addr  input  32  redirect target.
REQ-010 rom_req  output  1  ROM read request.
REQ-011 rom_addr  output  32  ROM word address.
REQ-012 rom_ack  input  1  ROM data valid; may be high in the same cycle as rom_req.
REQ-013 rom_data  input  32  ROM instruction word, valid when rom_ack=1.
REQ-014 valid_if  output  1  pc_if/inst valid toward the IF stage.
REQ-015 pc_if  output  32  PC of the head buffer entry.
REQ-016 inst  output  32  instruction of the head buffer entry.

Function
REQ-017 The block SHALL hold a PC register, a 2-entry FIFO of {pc, inst}, a 2-bit count (0..2) and an FSM with states IDLE, REQ and DROP.
REQ-018 valid_if SHALL equal (count!=0); pc_if and inst SHALL show the head entry combinationally, and SHALL be 0 when count=0.
REQ-019 A pop SHALL occur when valid_if=1, stall=0 and branch=0.
REQ-020 IDLE: rom_req=0; the FSM SHALL go to REQ when go=1, branch=0 and next-cycle count<2 (pops counted).
REQ-021 REQ: rom_req=1 and rom_addr=PC; both SHALL hold steady until rom_ack=1.
REQ-022 REQ with rom_ack=1 and branch=0: push {PC, rom_data}; PC<=PC+4; stay in REQ when go=1 and the post-update count<2, else go to IDLE.
REQ-023 Back-to-back operation: with rom_ack tied high, go=1 and stall=0, the block SHALL deliver one instruction per cycle.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-025 branch=1 SHALL take priority over push and pop in the same cycle: FIFO flushed (count<=0) and PC<={branch_addr[31:2],2'b00}.
REQ-026 A branch in IDLE SHALL send the FSM to REQ next cycle when go=1, else keep it in IDLE.
REQ-027 A branch in REQ with rom_ack=0 SHALL send the FSM to DROP.
REQ-028 A branch in REQ with rom_ack=1 SHALL discard the returning data and go to REQ (go=1) or IDLE (go=0).
REQ-029 DROP: rom_req=1 and rom_addr=the old request address; rom_ack SHALL be consumed without a push; then REQ (go=1) or IDLE.
REQ-030 A branch in DROP SHALL update PC, stay in DROP, and never push the stale data.
REQ-031 go=0 in REQ SHALL NOT cancel the outstanding request; its data SHALL be pushed, then the FSM SHALL enter IDLE.
REQ-032 The FIFO SHALL keep draining while go=0.
REQ-033 A push into a full FIFO SHALL be impossible by construction (REQ-020/022); an assertion SHALL flag count>2.

Reset
REQ-034 With reset=0 at a rising edge: PC<=RESET_PC, count<=0, FSM<=IDLE, FIFO contents<=0.
REQ-035 During and after reset, until the first request: rom_req=0, rom_addr=RESET_PC, valid_if=0, pc_if=0, inst=0.
REQ-036 Reset SHALL override branch, go and rom_ack in the same cycle; an outstanding request SHALL be abandoned and a late rom_ack ignored in IDLE.

Verification
REQ-037 Reset then go=1, rom_ack tied 1, stall=0 -> rom_addr 0,4,8... on consecutive cycles; valid_if=1 from the cycle after the first request; pc_if follows one cycle behind.
REQ-038 stall=1 held with ack=1 -> two entries buffered (pc 0,4), rom_req=0; release stall -> pc_if 0 then 4, fetch resumes at 8.
REQ-039 Request at 0x10 with ack delayed 3 cycles and branch to 0x103 in the 1st wait cycle -> DROP; rom_addr stays 0x10 until ack; data not delivered; next request 0x100.
REQ-040 Branch and pop in the same cycle with count=2 -> count=0 next cycle, valid_if=0, next fetch from the branch target.
REQ-041 Branch to 0xFFFFFFFC with ack tied 1 -> fetched pcs 0xFFFFFFFC then 0x00000000.
REQ-042 reset=0 asserted while in REQ awaiting ack, ack arriving one cycle later -> no push, valid_if=0, PC=RESET_PC.
